// File: rtl/ghosts_loc_ctrl_multi.sv
// rtl/ghosts_loc_ctrl_multi.sv - N-ghost move decision from a pipelined distance-map scan
// Optional horizontal tunnel wrap: define TUNNEL_WRAP_EN.
module ghosts_loc_ctrl_multi #(
    parameter int DELAY      = 50000000,
    parameter int NUM_GHOSTS = 4,
    parameter int X_W        = 6,
    parameter int Y_W        = 5,
    parameter int VAL_W      = 8,
    parameter int MAP_W      = 40,
    parameter int MAP_H      = 30,
    parameter int HOME_X     = 16,
    parameter int HOME_Y     = 13
) (
    input  logic                       CLOCK_50,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       frightened,
    input  logic                       map_ready,
    output logic [X_W-1:0]             rdaddr_x,
    output logic [Y_W-1:0]             rdaddr_y,
    input  logic [VAL_W-1:0]           data,
    input  logic                       wrdone,
    output logic                       decide_done,
    output logic [NUM_GHOSTS*X_W-1:0]  curr_x,
    output logic [NUM_GHOSTS*Y_W-1:0]  curr_y,
    output logic [NUM_GHOSTS*X_W-1:0]  next_x,
    output logic [NUM_GHOSTS*Y_W-1:0]  next_y
);

    localparam int CNT_W = (DELAY > 2) ? $clog2(DELAY) : 1;
    localparam int G_W   = (NUM_GHOSTS > 1) ? $clog2(NUM_GHOSTS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DELAY - 1);

    typedef enum logic [1:0] {IDLE, SCAN, FLUSH, COMMIT} state_t;

    typedef struct packed {
        logic           ok;
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
    } cand_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [G_W-1:0]      g_q, ev_g_q;
    logic [1:0]          d_q;
    logic                mode_q, done_q, ev_on_q;
    cand_t               ev_c_q, scan_c;
    logic                tick;

    logic [X_W-1:0]      curr_x_q [NUM_GHOSTS];
    logic [Y_W-1:0]      curr_y_q [NUM_GHOSTS];
    logic [X_W-1:0]      next_x_q [NUM_GHOSTS];
    logic [Y_W-1:0]      next_y_q [NUM_GHOSTS];
    logic [X_W-1:0]      prev_x_q [NUM_GHOSTS];
    logic [Y_W-1:0]      prev_y_q [NUM_GHOSTS];
    logic [X_W-1:0]      snap_x_q [NUM_GHOSTS];
    logic [Y_W-1:0]      snap_y_q [NUM_GHOSTS];
    logic [X_W-1:0]      sprev_x_q [NUM_GHOSTS];
    logic [Y_W-1:0]      sprev_y_q [NUM_GHOSTS];
    logic [X_W-1:0]      best_x_q [NUM_GHOSTS];
    logic [Y_W-1:0]      best_y_q [NUM_GHOSTS];
    logic [VAL_W-1:0]    best_v_q [NUM_GHOSTS];
    logic [X_W-1:0]      rev_x_q  [NUM_GHOSTS];
    logic [Y_W-1:0]      rev_y_q  [NUM_GHOSTS];
    logic [NUM_GHOSTS-1:0] best_ok_q, rev_ok_q;

    // Off-grid candidates keep a clamped in-range address so the RAM read stays legal.
    function automatic cand_t step_cand(input logic [X_W-1:0] x, input logic [Y_W-1:0] y,
                                        input logic [1:0] d);
        cand_t c;
        c.ok = 1'b1;
        c.x  = x;
        c.y  = y;
        case (d)
            2'd0: begin
                if (y == '0) c.ok = 1'b0;
                else         c.y  = y - Y_W'(1);
            end
            2'd1: begin
                if (32'(y) + 1 >= MAP_H) begin
                    c.ok = 1'b0;
                    c.y  = Y_W'(MAP_H - 1);
                end else begin
                    c.y  = y + Y_W'(1);
                end
            end
            2'd2: begin
                if (x == '0) begin
`ifdef TUNNEL_WRAP_EN
                    c.x  = X_W'(MAP_W - 1);
`else
                    c.ok = 1'b0;
`endif
                end else begin
                    c.x  = x - X_W'(1);
                end
            end
            default: begin
                if (32'(x) + 1 >= MAP_W) begin
`ifdef TUNNEL_WRAP_EN
                    c.x  = '0;
`else
                    c.ok = 1'b0;
                    c.x  = X_W'(MAP_W - 1);
`endif
                end else begin
                    c.x  = x + X_W'(1);
                end
            end
        endcase
        return c;
    endfunction

    assign tick = (cnt_q == LAST);

    always_comb begin
        scan_c = '0;
        for (int i = 0; i < NUM_GHOSTS; i++) begin
            if (g_q == G_W'(i)) scan_c = step_cand(snap_x_q[i], snap_y_q[i], d_q);
        end
        rdaddr_x = (state_q == SCAN) ? scan_c.x : '0;
        rdaddr_y = (state_q == SCAN) ? scan_c.y : '0;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            g_q     <= '0;
            d_q     <= '0;
            mode_q  <= 1'b0;
            done_q  <= 1'b0;
            ev_on_q <= 1'b0;
            ev_g_q  <= '0;
            ev_c_q  <= '0;
            best_ok_q <= '0;
            rev_ok_q  <= '0;
            for (int i = 0; i < NUM_GHOSTS; i++) begin
                curr_x_q[i]  <= X_W'(HOME_X + 7 * i);
                curr_y_q[i]  <= Y_W'(HOME_Y);
                next_x_q[i]  <= X_W'(HOME_X + 7 * i);
                next_y_q[i]  <= Y_W'(HOME_Y);
                prev_x_q[i]  <= X_W'(HOME_X + 7 * i);
                prev_y_q[i]  <= Y_W'(HOME_Y);
                snap_x_q[i]  <= X_W'(HOME_X + 7 * i);
                snap_y_q[i]  <= Y_W'(HOME_Y);
                sprev_x_q[i] <= X_W'(HOME_X + 7 * i);
                sprev_y_q[i] <= Y_W'(HOME_Y);
                best_x_q[i]  <= '0;
                best_y_q[i]  <= '0;
                best_v_q[i]  <= '0;
                rev_x_q[i]   <= '0;
                rev_y_q[i]   <= '0;
            end
        end else begin
            cnt_q   <= tick ? '0 : cnt_q + 1'b1;
            ev_on_q <= (state_q == SCAN);
            ev_g_q  <= g_q;
            ev_c_q  <= scan_c;

            if (wrdone) begin
                for (int i = 0; i < NUM_GHOSTS; i++) begin
                    prev_x_q[i] <= curr_x_q[i];
                    prev_y_q[i] <= curr_y_q[i];
                    curr_x_q[i] <= next_x_q[i];
                    curr_y_q[i] <= next_y_q[i];
                end
            end

            // data answers the address registered in ev_c_q one cycle earlier.
            if (ev_on_q && ev_c_q.ok && (data != {VAL_W{1'b1}})) begin
                for (int i = 0; i < NUM_GHOSTS; i++) begin
                    if (ev_g_q == G_W'(i)) begin
                        if (ev_c_q.x == sprev_x_q[i] && ev_c_q.y == sprev_y_q[i]) begin
                            rev_ok_q[i] <= 1'b1;
                            rev_x_q[i]  <= ev_c_q.x;
                            rev_y_q[i]  <= ev_c_q.y;
                        end else if (!best_ok_q[i] ||
                                     (mode_q ? (data > best_v_q[i]) : (data < best_v_q[i]))) begin
                            best_ok_q[i] <= 1'b1;
                            best_x_q[i]  <= ev_c_q.x;
                            best_y_q[i]  <= ev_c_q.y;
                            best_v_q[i]  <= data;
                        end
                    end
                end
            end

            case (state_q)
                IDLE: begin
                    if (tick && enable && map_ready) begin
                        state_q   <= SCAN;
                        mode_q    <= frightened;
                        g_q       <= '0;
                        d_q       <= '0;
                        best_ok_q <= '0;
                        rev_ok_q  <= '0;
                        for (int i = 0; i < NUM_GHOSTS; i++) begin
                            snap_x_q[i]  <= curr_x_q[i];
                            snap_y_q[i]  <= curr_y_q[i];
                            sprev_x_q[i] <= prev_x_q[i];
                            sprev_y_q[i] <= prev_y_q[i];
                        end
                    end
                end
                SCAN: begin
                    d_q <= d_q + 2'd1;
                    if (d_q == 2'd3) begin
                        if (g_q == G_W'(NUM_GHOSTS - 1)) state_q <= FLUSH;
                        else                             g_q     <= g_q + 1'b1;
                    end
                end
                FLUSH: begin
                    state_q <= COMMIT;
                    done_q  <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    for (int i = 0; i < NUM_GHOSTS; i++) begin
                        next_x_q[i] <= best_ok_q[i] ? best_x_q[i] :
                                       rev_ok_q[i]  ? rev_x_q[i]  : snap_x_q[i];
                        next_y_q[i] <= best_ok_q[i] ? best_y_q[i] :
                                       rev_ok_q[i]  ? rev_y_q[i]  : snap_y_q[i];
                    end
                end
            endcase
        end
    end

    assign decide_done = done_q;

    for (genvar i = 0; i < NUM_GHOSTS; i++) begin : g_pack
        assign curr_x[i*X_W +: X_W] = curr_x_q[i];
        assign curr_y[i*Y_W +: Y_W] = curr_y_q[i];
        assign next_x[i*X_W +: X_W] = next_x_q[i];
        assign next_y[i*Y_W +: Y_W] = next_y_q[i];
    end

endmodule
